// File: rtl/up_counter_4bit_pkg.sv
// Shared defaults and helpers for the up counter.
// Load values above the terminal value are clamped to it.
package up_counter_4bit_pkg;

  localparam int unsigned WIDTH_DEF = 4;
  localparam int unsigned MAX_DEF   = 15;

  function automatic logic [31:0] clamp_max(
    input logic [31:0] v,
    input logic [31:0] m
  );
    return (v > m) ? m : v;
  endfunction

endpackage

// File: rtl/up_counter_4bit_add_one.sv
// Combinational incrementer with carry-out.
// Fed from the count register in the top level.
module up_counter_4bit_add_one #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] o,
  output logic             co
);

  assign {co, o} = {1'b0, i} + {{WIDTH{1'b0}}, 1'b1};

endmodule

// File: rtl/up_counter_4bit.sv
// Modulo-(MAX+1) up counter with load, terminal count,
// registered wrap pulse and sticky overflow flag.
module up_counter_4bit
  import up_counter_4bit_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned MAX   = MAX_DEF
) (
  input  logic             clk,
  input  logic             set,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] o,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_n;
  logic [WIDTH-1:0] inc;
  logic [WIDTH-1:0] ld_val;
  logic             inc_co;
  logic             at_max;
  logic             roll;
  logic             wrap_q;
  logic             wrap_n;
  logic             ovf_q;
  logic             ovf_n;
  logic             do_load;
  logic             do_cnt;
  logic             do_hold;

  up_counter_4bit_add_one #(
    .WIDTH(WIDTH)
  ) u_add_one (
    .i (cnt_q),
    .o (inc),
    .co(inc_co)
  );

  assign ld_val = WIDTH'(clamp_max(32'(d), 32'(MAX)));

  // carry-out only fires at all-ones, which can only be MAX
  assign at_max = (cnt_q == MAX_W);
  assign roll   = at_max | inc_co;

  assign do_load = load;
  assign do_cnt  = ~load & en;
  assign do_hold = ~load & ~en;

  always_comb begin
    cnt_n  = cnt_q;
    wrap_n = 1'b0;
    ovf_n  = ovf_q & ~clr_ovf;
    unique case (1'b1)
      do_load: cnt_n = ld_val;
      do_cnt: begin
        if (roll) begin
          cnt_n  = '0;
          wrap_n = 1'b1;
          ovf_n  = 1'b1;
        end else begin
          cnt_n  = inc;
        end
      end
      do_hold: cnt_n = cnt_q;
      default: cnt_n = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (set) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_n;
      wrap_q <= wrap_n;
      ovf_q  <= ovf_n;
    end
  end

  assign o    = cnt_q;
  assign tc   = at_max & en;
  assign wrap = wrap_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_up_counter_4bit.sv
// Bench for up_counter_4bit: MAX=15 and MAX=9 instances
// on shared inputs plus a two-stage cascade.
module tb_up_counter_4bit;

  logic       clk = 1'b0;
  logic       set, en, load, clr_ovf;
  logic [3:0] d;
  logic       c_set, c_en;

  logic [3:0] a_o, b_o, lo_o, hi_o;
  logic       a_tc, a_wrap, a_ovf;
  logic       b_tc, b_wrap, b_ovf;
  logic       lo_tc, lo_wrap, lo_ovf;
  logic       hi_tc, hi_wrap, hi_ovf;

  int total = 0;
  int bad   = 0;

  int ma_o, mb_o, mc;
  bit ma_w, ma_v, mb_w, mb_v, mh_v;
  int hi_wraps;

  always #5 clk = ~clk;

  up_counter_4bit #(.WIDTH(4), .MAX(15)) dut_a (
    .clk(clk), .set(set), .en(en), .load(load), .d(d),
    .clr_ovf(clr_ovf), .o(a_o), .tc(a_tc),
    .wrap(a_wrap), .ovf(a_ovf)
  );

  up_counter_4bit #(.WIDTH(4), .MAX(9)) dut_b (
    .clk(clk), .set(set), .en(en), .load(load), .d(d),
    .clr_ovf(clr_ovf), .o(b_o), .tc(b_tc),
    .wrap(b_wrap), .ovf(b_ovf)
  );

  up_counter_4bit #(.WIDTH(4), .MAX(15)) dut_lo (
    .clk(clk), .set(c_set), .en(c_en), .load(1'b0),
    .d(4'd0), .clr_ovf(1'b0), .o(lo_o), .tc(lo_tc),
    .wrap(lo_wrap), .ovf(lo_ovf)
  );

  up_counter_4bit #(.WIDTH(4), .MAX(15)) dut_hi (
    .clk(clk), .set(c_set), .en(lo_tc), .load(1'b0),
    .d(4'd0), .clr_ovf(1'b0), .o(hi_o), .tc(hi_tc),
    .wrap(hi_wrap), .ovf(hi_ovf)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counter behaviour from its rules: count modulo m+1,
  // clamp loads, wrap pulse, sticky overflow.
  task automatic model(
    input  int m,
    input  bit s, input bit ld, input bit e, input bit clr,
    input  int dv,
    inout  int o, inout bit w, inout bit v
  );
    bit wrapped;
    wrapped = 1'b0;
    if (s) begin
      o = 0; w = 1'b0; v = 1'b0;
    end else begin
      if (ld) o = (dv > m) ? m : dv;
      else if (e) begin
        o = (o + 1) % (m + 1);
        wrapped = (o == 0);
      end
      w = wrapped;
      v = wrapped ? 1'b1 : (clr ? 1'b0 : v);
    end
  endtask

  task automatic step();
    #1;
    chk("a_tc", 32'(a_tc), 32'((ma_o == 15) && en));
    chk("b_tc", 32'(b_tc), 32'((mb_o == 9) && en));
    chk("lo_tc", 32'(lo_tc), 32'(((mc % 16) == 15) && c_en));
    chk("hi_tc", 32'(hi_tc), 32'((mc == 255) && c_en));
    model(15, set, load, en, clr_ovf, int'(d), ma_o, ma_w, ma_v);
    model(9, set, load, en, clr_ovf, int'(d), mb_o, mb_w, mb_v);
    if (c_set) begin
      mc = 0; mh_v = 1'b0;
    end else if (c_en) begin
      mc = (mc + 1) % 256;
      if (mc == 0) begin
        mh_v = 1'b1;
        hi_wraps++;
      end
    end
    @(posedge clk);
    #1;
    chk("a_o", 32'(a_o), 32'(ma_o));
    chk("a_wrap", 32'(a_wrap), 32'(ma_w));
    chk("a_ovf", 32'(a_ovf), 32'(ma_v));
    chk("b_o", 32'(b_o), 32'(mb_o));
    chk("b_wrap", 32'(b_wrap), 32'(mb_w));
    chk("b_ovf", 32'(b_ovf), 32'(mb_v));
    chk("b_range", 32'(b_o <= 4'd9), 32'd1);
    chk("casc", 32'({hi_o, lo_o}), 32'(mc));
    chk("hi_ovf", 32'(hi_ovf), 32'(mh_v));
  endtask

  task automatic drive(
    input bit s, input bit ld, input bit e,
    input bit clr, input logic [3:0] dv
  );
    set = s; load = ld; en = e; clr_ovf = clr; d = dv;
  endtask

  initial begin
    hi_wraps = 0;
    ma_o = 0; mb_o = 0; mc = 0;
    ma_w = 0; ma_v = 0; mb_w = 0; mb_v = 0; mh_v = 0;
    c_set = 1'b1; c_en = 1'b0;
    drive(1, 0, 0, 0, 4'd0);
    @(posedge clk);
    #1;
    chk("rst_a_o", 32'(a_o), 32'd0);
    chk("rst_a_wrap", 32'(a_wrap), 32'd0);
    chk("rst_a_ovf", 32'(a_ovf), 32'd0);
    chk("rst_b_o", 32'(b_o), 32'd0);
    chk("rst_casc", 32'({hi_o, lo_o}), 32'd0);
    c_set = 1'b0;

    // reset then count through a full wrap on both moduli
    drive(1, 0, 0, 0, 4'd0);
    step();
    for (int i = 0; i < 17; i++) begin
      drive(0, 0, 1, 0, 4'd0);
      step();
    end
    chk("t1_a_ovf", 32'(a_ovf), 32'd1);

    // load and clamp
    drive(0, 1, 0, 0, 4'd7);
    step();
    chk("t3_b_ld7", 32'(b_o), 32'd7);
    drive(0, 1, 0, 0, 4'd12);
    step();
    chk("t3_b_clamp", 32'(b_o), 32'd9);
    chk("t3_a_ld12", 32'(a_o), 32'd12);
    drive(0, 1, 1, 0, 4'd3);
    step();
    chk("t3_b_ld_en", 32'(b_o), 32'd3);
    chk("t3_b_nowrap", 32'(b_wrap), 32'd0);

    // wrap racing an overflow clear
    drive(0, 1, 0, 1, 4'd15);
    step();
    chk("t4_a_cleared", 32'(a_ovf), 32'd0);
    drive(0, 0, 1, 1, 4'd0);
    step();
    chk("t4_a_wrap", 32'(a_wrap), 32'd1);
    chk("t4_a_ovf_keep", 32'(a_ovf), 32'd1);
    drive(0, 0, 0, 1, 4'd0);
    step();
    chk("t4_a_ovf_clr", 32'(a_ovf), 32'd0);

    // reset while at terminal count
    drive(0, 0, 1, 0, 4'd0);
    for (int i = 0; i < 15; i++) step();
    chk("t5_a_at_max", 32'(a_o), 32'd15);
    drive(1, 0, 1, 0, 4'd0);
    step();
    chk("t5_a_o", 32'(a_o), 32'd0);
    chk("t5_a_wrap", 32'(a_wrap), 32'd0);
    chk("t5_a_ovf", 32'(a_ovf), 32'd0);

    // randomized mix
    for (int i = 0; i < 200; i++) begin
      drive(($urandom_range(0, 31) == 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0),
            4'($urandom_range(0, 15)));
      step();
    end

    // two-stage cascade
    drive(0, 0, 0, 0, 4'd0);
    c_set = 1'b1;
    step();
    c_set = 1'b0;
    c_en  = 1'b1;
    for (int i = 0; i < 256; i++) step();
    chk("t6_casc_zero", 32'({hi_o, lo_o}), 32'd0);
    chk("t6_hi_wrap", 32'(hi_wrap), 32'd1);
    chk("t6_hi_wraps", 32'(hi_wraps), 32'd1);
    c_en = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/up_counter_4bit.md
Name: up_counter_4bit

Overview:
- Synchronous binary up-counter, the counting-direction complement of the team's 4-bit down counter.
- Counts 0 -> MAX, then wraps to 0.
- Supports count enable, parallel load, a terminal-count output for cascading, a registered wrap pulse and a sticky overflow flag.
- Used as a cycle/event counter and as the low stage of wider cascaded counters.

Parameters:
- WIDTH, 4, counter width in bits.
- MAX, 15, terminal value (inclusive). Count wraps to 0 after MAX. Legal range 1..2^WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- set  input  1  synchronous active-high reset; returns the block to its initial state.
- en  input  1  count enable; increment on the clock edge when high.
- load  input  1  synchronous parallel load.
- d  input  WIDTH  load value.
- clr_ovf  input  1  synchronous clear of the sticky overflow flag.
- o  output  WIDTH  current count (registered).
- tc  output  1  terminal count, combinational: (o == MAX) && en. Drives the next stage's en when cascading.
- wrap  output  1  registered one-cycle pulse, high in the cycle after o wrapped MAX -> 0.
- ovf  output  1  sticky flag, set on any wrap, held until clr_ovf or set.

Behaviour:
- Reset (set=1 at a clock edge): o=0, wrap=0, ovf=0. Overrides every other input. tc follows from o=0 (tc=0 unless MAX=0, which is illegal).
- Priority per edge: set > load > en > hold.
- load=1:
  - o <= d if d <= MAX; otherwise o <= MAX (clamped).
  - wrap <= 0; ovf unchanged.
  - en is ignored that cycle.
- en=1, load=0:
  - If o < MAX: o <= o+1, wrap <= 0.
  - If o == MAX: o <= 0, wrap <= 1, ovf <= 1.
- en=0, load=0: o holds, wrap <= 0.
- ovf:
  - A wrap and clr_ovf in the same cycle leave ovf=1 (set wins over clear).
  - clr_ovf alone gives ovf <= 0.
- Latency:
  - o changes 1 cycle after the qualifying edge.
  - wrap asserts in the same cycle o shows 0 after a wrap.
  - tc is combinational, with no latency.
- Width rules:
  - Increment is modulo MAX+1, never modulo 2^WIDTH unless MAX = 2^WIDTH-1.
  - No value above MAX is ever observable on o.
- Reset mid-count: set with en=1 and o=MAX gives o=0, wrap=0, ovf=0. The reset does not count as a wrap.
- Cascading: stage k+1 en = stage k tc. The chain increments exactly once per low-stage wrap.

Decomposition:
- Shared package: WIDTH default, and function/constant for clamp to MAX.
- Sub-module add_one: combinational WIDTH-bit incrementer, i -> o = i+1, with a carry-out.
  - Counterpart of the existing subOne.
  - Instantiated with the register output fed back, as in the down counter.
- Top level holds the state register plus the compare/wrap/ovf logic.

Test Plan:
1. Reset then count: set=1 for 1 cycle, then en=1 for 16 cycles -> o steps 0,1,...,15,0; wrap=1 only in the cycle o returns to 0; ovf=1 from then on; tc=1 only while o=15.
2. Modulus: MAX=9, en=1 from 0 -> sequence 0..9,0; tc high at 9; o never shows 10..15.
3. Load and clamp (MAX=9): load=1 with d=7 -> o=7. Next load with d=12 -> o=9. load=1 with en=1 at o=9 gives o=d and no wrap.
4. Overflow clear race: wrap with clr_ovf=1 in the same cycle -> ovf stays 1. Next cycle clr_ovf=1, en=0 -> ovf=0.
5. Reset mid-operation: o=15, en=1, set=1 -> o=0, wrap=0, ovf=0.
6. Cascade: two instances chained via tc -> en, en=1 on the low stage for 256 cycles -> {hi,lo} counts 0x00..0xFF then 0x00; hi ovf set exactly once.
